// File: rtl/nest_keyword_checker_pkg.sv
// Shared types, ASCII constants and character helpers for the begin/end nesting checker.
package nest_keyword_checker_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SKIP  = 4'd1,
    ST_B     = 4'd2,
    ST_BE    = 4'd3,
    ST_BEG   = 4'd4,
    ST_BEGI  = 4'd5,
    ST_BEGIN = 4'd6,
    ST_E     = 4'd7,
    ST_EN    = 4'd8,
    ST_END   = 4'd9
  } state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_D     = 8'h64;

  function automatic logic is_delim(input logic [7:0] c, input logic ext);
    if (c == CH_SPACE) return 1'b1;
    if (ext && (c == CH_TAB || c == CH_LF || c == CH_CR)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c, input logic fold);
    if (fold && c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/nest_keyword_checker_depth_counter.sv
// Saturating nesting-depth counter with sticky underflow/overflow flags.
module nest_depth_counter
  import nest_keyword_checker_pkg::*;
#(
  parameter int DEPTH_W   = 8,
  parameter int MAX_DEPTH = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_underflow,
  output logic               err_overflow
);

  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE   = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] ZERO  = '0;

  logic [DEPTH_W-1:0] depth_reg;
  logic               underflow_reg;
  logic               overflow_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_reg     <= ZERO;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (clear) begin
      depth_reg     <= ZERO;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (inc) begin
      // Depth holds at the limit; only the sticky flag records the attempt.
      if (depth_reg == MAX_D) overflow_reg <= 1'b1;
      else                    depth_reg    <= depth_reg + ONE;
    end else if (dec) begin
      if (depth_reg == ZERO) underflow_reg <= 1'b1;
      else                   depth_reg     <= depth_reg - ONE;
    end
  end

  assign depth         = depth_reg;
  assign err_underflow = underflow_reg;
  assign err_overflow  = overflow_reg;

endmodule

// File: rtl/nest_keyword_checker.sv
// Byte-per-cycle checker for balanced "begin"/"end" keyword nesting in an ASCII stream.
module nest_keyword_checker
  import nest_keyword_checker_pkg::*;
#(
  parameter int DEPTH_W   = 8,
  parameter int MAX_DEPTH = 255,
  parameter int CASE_SENS = 0,
  parameter int EXT_DELIM = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_underflow,
  output logic               err_overflow
);

  state_t     state_reg;
  logic [7:0] ch;
  logic       delim;
  logic       commit_begin;
  logic       commit_end;

  assign ch    = to_lower(in, CASE_SENS == 0);
  assign delim = is_delim(in, EXT_DELIM != 0);

  // A keyword commits only when its delimiter is actually consumed.
  assign commit_begin = in_valid && !clear && delim && (state_reg == ST_BEGIN);
  assign commit_end   = in_valid && !clear && delim && (state_reg == ST_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else if (clear) begin
      state_reg <= ST_IDLE;
    end else if (in_valid) begin
      if (delim) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (ch == CH_B)      state_reg <= ST_B;
            else if (ch == CH_E) state_reg <= ST_E;
            else                 state_reg <= ST_SKIP;
          end
          ST_B:    state_reg <= (ch == CH_E) ? ST_BE    : ST_SKIP;
          ST_BE:   state_reg <= (ch == CH_G) ? ST_BEG   : ST_SKIP;
          ST_BEG:  state_reg <= (ch == CH_I) ? ST_BEGI  : ST_SKIP;
          ST_BEGI: state_reg <= (ch == CH_N) ? ST_BEGIN : ST_SKIP;
          ST_E:    state_reg <= (ch == CH_N) ? ST_EN    : ST_SKIP;
          ST_EN:   state_reg <= (ch == CH_D) ? ST_END   : ST_SKIP;
          // SKIP, and complete keywords followed by more letters ("beginx", "ends")
          default: state_reg <= ST_SKIP;
        endcase
      end
    end
  end

  nest_depth_counter #(
    .DEPTH_W  (DEPTH_W),
    .MAX_DEPTH(MAX_DEPTH)
  ) u_depth (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .inc          (commit_begin),
    .dec          (commit_end),
    .depth        (depth),
    .err_underflow(err_underflow),
    .err_overflow (err_overflow)
  );

  // The pending word is judged as if its delimiter had already arrived.
  always_comb begin
    result = 1'b0;
    if (err_underflow || err_overflow) result = 1'b0;
    else if (state_reg == ST_BEGIN)    result = 1'b0;
    else if (state_reg == ST_END)      result = (depth == DEPTH_W'(1));
    else                               result = (depth == '0);
  end

endmodule
